// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared constants for the ID/EX pipeline boundary.
// Holds the default widths, the bubble reset encodings of the decoded
// controls, and the halt-drain FSM state encoding.
package id_ex_stage_pkg;

  // Default geometry of the stage
  localparam int NB_DEFAULT            = 32;
  localparam int NB_REGS_DEFAULT       = 5;
  localparam int NB_SIZE_TYPE_DEFAULT  = 3;
  localparam int DRAIN_CYCLES_DEFAULT  = 3;  // EX, MEM, WB drain after HALT
  localparam int NB_BUBBLE_CNT_DEFAULT = 16;

  // Control encodings that a bubble carries instead of zero
  localparam logic       RT_ALU_SRC            = 1'b0;    // ALU B operand from rt
  localparam logic [1:0] SIGNED_EXTENSION_MODE = 2'b01;
  localparam logic [2:0] COMPLETE_WORD         = 3'b011;

  // Halt-drain FSM states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

  // Width of a down-counter that must hold DRAIN_CYCLES-1
  function automatic int drain_cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags a load in EX whose destination is read by the
// instruction currently in ID. Register 0 is never a hazard destination.
module load_use_detector
  import id_ex_stage_pkg::*;
#(
  parameter int NB_REGS = NB_REGS_DEFAULT
) (
  input  logic               ex_mem_read_i,
  input  logic [NB_REGS-1:0] ex_rd_i,
  input  logic [NB_REGS-1:0] id_rs_i,
  input  logic [NB_REGS-1:0] id_rt_i,
  output logic               hazard_o
);

  logic rd_nonzero;
  logic rd_matches;

  assign rd_nonzero = (ex_rd_i != '0);
  assign rd_matches = (ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i);
  assign hazard_o   = ex_mem_read_i && rd_nonzero && rd_matches;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Captures the decoded control bundle and operands, inserts bubbles for
// load-use hazards (stalling PC and IF/ID) and for taken branch/jump
// flushes, and drains the pipeline after HALT before raising o_halted.
// Optional build macro ID_EX_BUBBLE_COUNTER_EN adds a saturating counter of
// flush/load-use bubbles on o_bubble_count; otherwise that port is tied to 0.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int NB            = NB_DEFAULT,
  parameter int NB_REGS       = NB_REGS_DEFAULT,
  parameter int NB_SIZE_TYPE  = NB_SIZE_TYPE_DEFAULT,
  parameter int DRAIN_CYCLES  = DRAIN_CYCLES_DEFAULT,
  parameter int NB_BUBBLE_CNT = NB_BUBBLE_CNT_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_step,
  input  logic                     i_flush,
  // Decoded controls from ID
  input  logic                     i_ALUSrc,
  input  logic                     i_mem_read,
  input  logic                     i_mem_write,
  input  logic                     i_mem_to_reg,
  input  logic                     i_reg_write,
  input  logic                     i_branch,
  input  logic                     i_jump,
  input  logic                     i_halt,
  input  logic                     i_signed,
  input  logic [1:0]               i_ExtensionMode,
  input  logic [NB_SIZE_TYPE-1:0]  i_word_size,
  input  logic [NB_REGS-1:0]       i_reg_dir_to_write,
  // Source registers of the instruction in ID
  input  logic [NB_REGS-1:0]       i_rs_dir,
  input  logic [NB_REGS-1:0]       i_rt_dir,
  // Operands
  input  logic [NB-1:0]            i_rs_data,
  input  logic [NB-1:0]            i_rt_data,
  input  logic [NB-1:0]            i_imm_ext,
  input  logic [NB-1:0]            i_pc4,
  // EX-stage copies
  output logic                     o_ALUSrc,
  output logic                     o_mem_read,
  output logic                     o_mem_write,
  output logic                     o_mem_to_reg,
  output logic                     o_reg_write,
  output logic                     o_branch,
  output logic                     o_jump,
  output logic                     o_halt,
  output logic                     o_signed,
  output logic [1:0]               o_ExtensionMode,
  output logic [NB_SIZE_TYPE-1:0]  o_word_size,
  output logic [NB_REGS-1:0]       o_reg_dir_to_write,
  output logic [NB_REGS-1:0]       o_rs_dir,
  output logic [NB_REGS-1:0]       o_rt_dir,
  output logic [NB-1:0]            o_rs_data,
  output logic [NB-1:0]            o_rt_data,
  output logic [NB-1:0]            o_imm_ext,
  output logic [NB-1:0]            o_pc4,
  // Pipeline control
  output logic                     o_stall,
  output logic                     o_halted,
  output logic [NB_BUBBLE_CNT-1:0] o_bubble_count
);

  localparam int                  NB_DRAIN   = drain_cnt_width(DRAIN_CYCLES);
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  localparam logic [NB_SIZE_TYPE-1:0] WORD_SIZE_RST = NB_SIZE_TYPE'(COMPLETE_WORD);

  // ---------------------------------------------------------------------------
  // Pipeline registers and their next-state values
  // ---------------------------------------------------------------------------
  logic                    alu_src_q,     alu_src_d;
  logic                    mem_read_q,    mem_read_d;
  logic                    mem_write_q,   mem_write_d;
  logic                    mem_to_reg_q,  mem_to_reg_d;
  logic                    reg_write_q,   reg_write_d;
  logic                    branch_q,      branch_d;
  logic                    jump_q,        jump_d;
  logic                    halt_q,        halt_d;
  logic                    signed_q,      signed_d;
  logic [1:0]              ext_mode_q,    ext_mode_d;
  logic [NB_SIZE_TYPE-1:0] word_size_q,   word_size_d;
  logic [NB_REGS-1:0]      rd_q,          rd_d;
  logic [NB_REGS-1:0]      rs_dir_q,      rs_dir_d;
  logic [NB_REGS-1:0]      rt_dir_q,      rt_dir_d;
  logic [NB-1:0]           rs_data_q,     rs_data_d;
  logic [NB-1:0]           rt_data_q,     rt_data_d;
  logic [NB-1:0]           imm_ext_q,     imm_ext_d;
  logic [NB-1:0]           pc4_q,         pc4_d;

  // Halt-drain FSM
  halt_state_e             state_q;
  logic [NB_DRAIN-1:0]     drain_cnt_q;
  logic                    halted_q;

  // Pipeline decisions for this cycle
  logic load_use;
  logic running;
  logic load_bubble;
  logic capture_halt;

  load_use_detector #(
    .NB_REGS (NB_REGS)
  ) u_load_use_detector (
    .ex_mem_read_i (mem_read_q),
    .ex_rd_i       (rd_q),
    .id_rs_i       (i_rs_dir),
    .id_rt_i       (i_rt_dir),
    .hazard_o      (load_use)
  );

  assign running = (state_q == ST_RUN);

  // Flush outranks load-use: the dependent instruction is being discarded
  // anyway, so ID must not be frozen. Outside RUN the front end stays frozen.
  assign o_stall      = (load_use & ~i_flush & running) | ~running;
  assign load_bubble  = ~running | i_flush | load_use;
  assign capture_halt = running & ~i_flush & ~load_use & i_halt;

  // Select between capturing the ID bundle and loading a bubble
  always_comb begin
    // NOTE: every _d gets its default first so no path through this block can infer a latch.
    alu_src_d    = i_ALUSrc;
    mem_read_d   = i_mem_read;
    mem_write_d  = i_mem_write;
    mem_to_reg_d = i_mem_to_reg;
    reg_write_d  = i_reg_write;
    branch_d     = i_branch;
    jump_d       = i_jump;
    halt_d       = i_halt;
    signed_d     = i_signed;
    ext_mode_d   = i_ExtensionMode;
    word_size_d  = i_word_size;
    rd_d         = i_reg_dir_to_write;
    rs_dir_d     = i_rs_dir;
    rt_dir_d     = i_rt_dir;
    rs_data_d    = i_rs_data;
    rt_data_d    = i_rt_data;
    imm_ext_d    = i_imm_ext;
    pc4_d        = i_pc4;
    if (load_bubble) begin
      alu_src_d    = RT_ALU_SRC;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      branch_d     = 1'b0;
      jump_d       = 1'b0;
      halt_d       = 1'b0;
      signed_d     = 1'b0;
      ext_mode_d   = SIGNED_EXTENSION_MODE;
      word_size_d  = WORD_SIZE_RST;
      rd_d         = '0;
      rs_dir_d     = '0;
      rt_dir_d     = '0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_ext_d    = '0;
      pc4_d        = '0;
    end
  end

  // EX-stage register bank; holds while the pipeline is not stepped
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
      alu_src_q    <= RT_ALU_SRC;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      halt_q       <= 1'b0;
      signed_q     <= 1'b0;
      ext_mode_q   <= SIGNED_EXTENSION_MODE;
      word_size_q  <= WORD_SIZE_RST;
      rd_q         <= '0;
      rs_dir_q     <= '0;
      rt_dir_q     <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_ext_q    <= '0;
      pc4_q        <= '0;
    end else if (i_step) begin
      alu_src_q    <= alu_src_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      halt_q       <= halt_d;
      signed_q     <= signed_d;
      ext_mode_q   <= ext_mode_d;
      word_size_q  <= word_size_d;
      rd_q         <= rd_d;
      rs_dir_q     <= rs_dir_d;
      rt_dir_q     <= rt_dir_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_ext_q    <= imm_ext_d;
      pc4_q        <= pc4_d;
    end
  end

  // Halt-drain FSM: a captured HALT waits DRAIN_CYCLES stepped edges, then
  // reports halted until reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else if (i_step) begin
      unique case (state_q)
        ST_RUN: begin
          if (capture_halt) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - NB_DRAIN'(1);
          end
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_RUN;
          drain_cnt_q <= '0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ID_EX_BUBBLE_COUNTER_EN
  logic [NB_BUBBLE_CNT-1:0] bubble_cnt_q;
  logic                     count_bubble;

  // Drain/halted bubbles are not hazards, so only RUN-state bubbles count
  assign count_bubble = running & (i_flush | load_use);

  // Saturating count of flush and load-use bubbles
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bubble_cnt_q <= '0;
    end else if (i_step && count_bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + NB_BUBBLE_CNT'(1);
    end
  end

  assign o_bubble_count = bubble_cnt_q;
`else
  assign o_bubble_count = '0;
`endif

  assign o_ALUSrc           = alu_src_q;
  assign o_mem_read         = mem_read_q;
  assign o_mem_write        = mem_write_q;
  assign o_mem_to_reg       = mem_to_reg_q;
  assign o_reg_write        = reg_write_q;
  assign o_branch           = branch_q;
  assign o_jump             = jump_q;
  assign o_halt             = halt_q;
  assign o_signed           = signed_q;
  assign o_ExtensionMode    = ext_mode_q;
  assign o_word_size        = word_size_q;
  assign o_reg_dir_to_write = rd_q;
  assign o_rs_dir           = rs_dir_q;
  assign o_rt_dir           = rt_dir_q;
  assign o_rs_data          = rs_data_q;
  assign o_rt_data          = rt_data_q;
  assign o_imm_ext          = imm_ext_q;
  assign o_pc4              = pc4_q;
  assign o_halted           = halted_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed bench for id_ex_stage, compared
// every cycle against a behavioural model of the stage, plus literal
// expectations for capture, load-use, flush, halt drain, step hold and reset.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int NB = 32, NB_REGS = 5, NB_SIZE_TYPE = 3, DRAIN_CYCLES = 3, NB_BC = 16;
`ifdef ID_EX_BUBBLE_COUNTER_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  logic clk, i_reset, i_step, i_flush;
  logic i_ALUSrc, i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write;
  logic i_branch, i_jump, i_halt, i_signed;
  logic [1:0]              i_ExtensionMode;
  logic [NB_SIZE_TYPE-1:0] i_word_size;
  logic [NB_REGS-1:0]      i_reg_dir_to_write, i_rs_dir, i_rt_dir;
  logic [NB-1:0]           i_rs_data, i_rt_data, i_imm_ext, i_pc4;

  logic o_ALUSrc, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;
  logic o_branch, o_jump, o_halt, o_signed;
  logic [1:0]              o_ExtensionMode;
  logic [NB_SIZE_TYPE-1:0] o_word_size;
  logic [NB_REGS-1:0]      o_reg_dir_to_write, o_rs_dir, o_rt_dir;
  logic [NB-1:0]           o_rs_data, o_rt_data, o_imm_ext, o_pc4;
  logic                    o_stall, o_halted;
  logic [NB_BC-1:0]        o_bubble_count;

  id_ex_stage #(
    .NB(NB), .NB_REGS(NB_REGS), .NB_SIZE_TYPE(NB_SIZE_TYPE),
    .DRAIN_CYCLES(DRAIN_CYCLES), .NB_BUBBLE_CNT(NB_BC)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
    .i_ALUSrc(i_ALUSrc), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write), .i_branch(i_branch),
    .i_jump(i_jump), .i_halt(i_halt), .i_signed(i_signed),
    .i_ExtensionMode(i_ExtensionMode), .i_word_size(i_word_size),
    .i_reg_dir_to_write(i_reg_dir_to_write), .i_rs_dir(i_rs_dir), .i_rt_dir(i_rt_dir),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm_ext(i_imm_ext), .i_pc4(i_pc4),
    .o_ALUSrc(o_ALUSrc), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_branch(o_branch),
    .o_jump(o_jump), .o_halt(o_halt), .o_signed(o_signed),
    .o_ExtensionMode(o_ExtensionMode), .o_word_size(o_word_size),
    .o_reg_dir_to_write(o_reg_dir_to_write), .o_rs_dir(o_rs_dir), .o_rt_dir(o_rt_dir),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_pc4(o_pc4),
    .o_stall(o_stall), .o_halted(o_halted), .o_bubble_count(o_bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: contents of EX, halt countdown, bubble tally
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, halt, sgn;
    logic [1:0]              ext;
    logic [NB_SIZE_TYPE-1:0] ws;
    logic [NB_REGS-1:0]      rd, rs, rt;
    logic [NB-1:0]           rs_data, rt_data, imm, pc4;
  } ex_t;

  ex_t       m_ex;
  int        m_left;    // stepped edges still to wait after a captured HALT
  bit        m_halted;
  int        m_bubbles;
  bit        cmp_en = 1'b0;

  function automatic ex_t bubble();
    ex_t b = '0;
    b.alu_src = RT_ALU_SRC;
    b.ext     = SIGNED_EXTENSION_MODE;
    b.ws      = COMPLETE_WORD;
    return b;
  endfunction

  function automatic bit m_running();
    return !m_halted && (m_left == 0);
  endfunction

  function automatic bit m_hazard();
    return m_ex.mem_read && (m_ex.rd != 0) &&
           ((m_ex.rd == i_rs_dir) || (m_ex.rd == i_rt_dir));
  endfunction

  function automatic bit m_stall();
    return !m_running() || (m_hazard() && !i_flush);
  endfunction

  task automatic m_reset();
    m_ex = bubble(); m_left = 0; m_halted = 1'b0; m_bubbles = 0;
  endtask

  task automatic m_step();
    ex_t cap;
    if (!m_running()) begin
      m_ex = bubble();
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_halted = 1'b1;
      end
    end else if (i_flush || m_hazard()) begin
      m_ex = bubble();
      if (m_bubbles < (1 << NB_BC) - 1) m_bubbles++;
    end else begin
      cap = {i_ALUSrc, i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write, i_branch,
             i_jump, i_halt, i_signed, i_ExtensionMode, i_word_size, i_reg_dir_to_write,
             i_rs_dir, i_rt_dir, i_rs_data, i_rt_data, i_imm_ext, i_pc4};
      m_ex = cap;
      if (i_halt) m_left = DRAIN_CYCLES;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge i_reset);
      if (i_reset) m_reset();
      else if (i_step) m_step();
    end
  end

  // Compare every cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("ctrl", {o_ALUSrc, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write,
                       o_branch, o_jump, o_halt, o_signed, o_ExtensionMode, o_word_size},
              {m_ex.alu_src, m_ex.mem_read, m_ex.mem_write, m_ex.mem_to_reg, m_ex.reg_write,
               m_ex.branch, m_ex.jump, m_ex.halt, m_ex.sgn, m_ex.ext, m_ex.ws});
        check("regs", {o_reg_dir_to_write, o_rs_dir, o_rt_dir}, {m_ex.rd, m_ex.rs, m_ex.rt});
        check("rs_data", o_rs_data, m_ex.rs_data);
        check("rt_data", o_rt_data, m_ex.rt_data);
        check("imm_ext", o_imm_ext, m_ex.imm);
        check("pc4", o_pc4, m_ex.pc4);
        check("stall", o_stall, m_stall());
        check("halted", o_halted, m_halted);
        check("bubble_count", o_bubble_count, BC_EN ? NB_BC'(m_bubbles) : '0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_nop();
    i_step = 1'b1; i_flush = 1'b0;
    i_ALUSrc = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_to_reg = 1'b0;
    i_reg_write = 1'b0; i_branch = 1'b0; i_jump = 1'b0; i_halt = 1'b0; i_signed = 1'b0;
    i_ExtensionMode = 2'b01; i_word_size = 3'b011;
    i_reg_dir_to_write = '0; i_rs_dir = '0; i_rt_dir = '0;
    i_rs_data = '0; i_rt_data = '0; i_imm_ext = '0; i_pc4 = '0;
  endtask

  function automatic logic [NB_REGS-1:0] pick_reg();
    logic [NB_REGS-1:0] r;
    case ($urandom_range(0, 3))
      0:       r = '0;
      1:       r = 5'd8;
      2:       r = NB_REGS'($urandom_range(1, 3));
      default: r = NB_REGS'($urandom);
    endcase
    return r;
  endfunction

  task automatic set_random();
    i_step = ($urandom_range(0, 9) != 0);
    i_flush = ($urandom_range(0, 6) == 0);
    {i_ALUSrc, i_mem_write, i_mem_to_reg, i_reg_write, i_branch, i_jump, i_signed} = 7'($urandom);
    i_mem_read = $urandom_range(0, 1) == 1;
    i_halt = 1'b0;
    i_ExtensionMode = 2'($urandom); i_word_size = 3'($urandom);
    i_reg_dir_to_write = pick_reg(); i_rs_dir = pick_reg(); i_rt_dir = pick_reg();
    i_rs_data = $urandom; i_rt_data = $urandom; i_imm_ext = $urandom; i_pc4 = $urandom;
  endtask

  task automatic step_clk();
    @(posedge clk);
    #2;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    i_reset = 1'b1;
    set_nop();
    step_clk();
    check("rst_alusrc", o_ALUSrc, RT_ALU_SRC);
    check("rst_ext", o_ExtensionMode, 2'b01);
    check("rst_ws", o_word_size, 3'b011);
    check("rst_halted", o_halted, 1'b0);
    step_clk();
    i_reset = 1'b0;
    cmp_en  = 1'b1;

    // Capture an ADDI-style instruction
    i_reg_write = 1'b1; i_ALUSrc = 1'b1; i_reg_dir_to_write = 5'd5;
    i_rs_dir = 5'd1; i_rt_dir = 5'd2; i_rs_data = 32'h10; i_imm_ext = 32'h4;
    step_clk();
    @(negedge clk);
    check("addi_rd", o_reg_dir_to_write, 5'd5);
    check("addi_rs_data", o_rs_data, 32'h10);
    check("addi_imm", o_imm_ext, 32'h4);
    check("addi_stall", o_stall, 1'b0);

    // Load-use: LW r8 then a reader of r8
    set_nop(); i_mem_read = 1'b1; i_mem_to_reg = 1'b1; i_reg_write = 1'b1;
    i_reg_dir_to_write = 5'd8; i_rs_dir = 5'd1; i_rt_dir = 5'd2;
    step_clk();
    set_nop(); i_reg_write = 1'b1; i_reg_dir_to_write = 5'd9; i_rs_dir = 5'd8; i_rt_dir = 5'd3;
    @(negedge clk);
    check("lu_stall", o_stall, 1'b1);
    step_clk();
    @(negedge clk);
    check("lu_bubble_memrd", o_mem_read, 1'b0);
    check("lu_bubble_regwr", o_reg_write, 1'b0);
    check("lu_stall_once", o_stall, 1'b0);
    step_clk();
    @(negedge clk);
    check("lu_recapture_rd", o_reg_dir_to_write, 5'd9);
    check("lu_recapture_regwr", o_reg_write, 1'b1);

    // Load to r0 never stalls
    set_nop(); i_mem_read = 1'b1; i_reg_dir_to_write = 5'd0; i_rs_dir = 5'd3; i_rt_dir = 5'd4;
    step_clk();
    set_nop(); i_reg_write = 1'b1; i_reg_dir_to_write = 5'd10;
    @(negedge clk);
    check("r0_no_stall", o_stall, 1'b0);
    step_clk();
    @(negedge clk);
    check("r0_capture_rd", o_reg_dir_to_write, 5'd10);

    // Flush beats load-use
    set_nop(); i_mem_read = 1'b1; i_reg_dir_to_write = 5'd8; i_rs_dir = 5'd1; i_rt_dir = 5'd2;
    step_clk();
    set_nop(); i_rs_dir = 5'd8; i_reg_dir_to_write = 5'd11; i_reg_write = 1'b1; i_flush = 1'b1;
    @(negedge clk);
    check("flush_no_stall", o_stall, 1'b0);
    step_clk();
    i_flush = 1'b0;
    @(negedge clk);
    check("flush_bubble_regwr", o_reg_write, 1'b0);
    check("flush_bubble_rd", o_reg_dir_to_write, 5'd0);
    check("flush_bubble_count", o_bubble_count, BC_EN ? 16'd2 : 16'd0);

    // Randomized traffic, no HALT
    for (int i = 0; i < 1500; i++) begin
      set_random();
      step_clk();
    end

    // HALT with a 5-cycle step hold during the drain
    set_nop(); i_halt = 1'b1;
    step_clk();
    set_random(); i_step = 1'b1; i_halt = 1'b1;
    @(negedge clk);
    check("halt_captured", o_halt, 1'b1);
    check("halt_stall", o_stall, 1'b1);
    step_clk();
    @(negedge clk);
    check("drain1_halted", o_halted, 1'b0);
    for (int i = 0; i < 5; i++) begin
      i_step = 1'b0;
      step_clk();
      @(negedge clk);
      check("hold_halted", o_halted, 1'b0);
    end
    i_step = 1'b1;
    step_clk();
    @(negedge clk);
    check("drain2_halted", o_halted, 1'b0);
    step_clk();
    @(negedge clk);
    check("drain3_halted", o_halted, 1'b1);
    repeat (3) begin
      set_random(); i_step = 1'b1;
      step_clk();
    end

    // Asynchronous reset mid-clock while halted
    #1 i_reset = 1'b1;
    #1;
    check("areset_halted", o_halted, 1'b0);
    check("areset_alusrc", o_ALUSrc, RT_ALU_SRC);
    check("areset_regwr", o_reg_write, 1'b0);
    step_clk();
    set_nop();
    i_reset = 1'b0;
    i_reg_write = 1'b1; i_reg_dir_to_write = 5'd7;
    @(negedge clk);
    check("post_reset_stall", o_stall, 1'b0);
    step_clk();
    @(negedge clk);
    check("post_reset_capture", o_reg_dir_to_write, 5'd7);

    // Plain HALT: halted exactly DRAIN_CYCLES edges after capture
    set_nop(); i_halt = 1'b1;
    step_clk();
    set_nop(); i_reg_write = 1'b1; i_reg_dir_to_write = 5'd12;
    @(negedge clk);
    check("t0_halted", o_halted, 1'b0);
    step_clk(); @(negedge clk);
    check("t1_halted", o_halted, 1'b0);
    check("t1_stall", o_stall, 1'b1);
    step_clk(); @(negedge clk);
    check("t2_halted", o_halted, 1'b0);
    step_clk(); @(negedge clk);
    check("t3_halted", o_halted, 1'b1);
    check("t3_ignored_rd", o_reg_dir_to_write, 5'd0);
    step_clk(); @(negedge clk);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary, directly downstream of the decode control unit.
- Registers the decoded control bundle and operands into the EX stage.
- Detects load-use hazards and inserts bubbles; drives the stall signal to PC and IF/ID.
- Turns taken-branch/jump flushes into bubbles, and runs the halt-drain FSM that reports when the pipeline is empty after HALT.

Parameters:
NB, 32, datapath width
NB_REGS, 5, register address width
NB_SIZE_TYPE, 3, word-size code width
DRAIN_CYCLES, 3, cycles after HALT enters EX before o_halted (EX, MEM, WB drain)
NB_BUBBLE_CNT, 16, bubble counter width

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_step  in  1  pipeline enable (debug step / run); 0 = hold all state
i_flush  in  1  taken branch/jump in EX; replace the incoming instruction with a bubble
i_ALUSrc, i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write, i_branch, i_jump, i_halt, i_signed  in  1 each  decoded controls
i_ExtensionMode  in  2  extension mode
i_word_size  in  NB_SIZE_TYPE  access size
i_reg_dir_to_write  in  NB_REGS  destination register
i_rs_dir, i_rt_dir  in  NB_REGS  source registers of the instruction in ID
i_rs_data, i_rt_data, i_imm_ext, i_pc4  in  NB each  operands
o_<each control/data above>  out  same widths  registered EX-stage copies
o_stall  out  1  combinational; freeze PC and IF/ID this cycle
o_halted  out  1  pipeline fully drained after HALT
o_bubble_count  out  NB_BUBBLE_CNT  bubbles inserted (optional feature)

Behaviour:
- Reset (async, i_reset=1): all o_* registers go to 0, except o_ALUSrc=RT_ALU_SRC, o_ExtensionMode=SIGNED_EXTENSION_MODE, o_word_size=COMPLETE_WORD. FSM goes to RUN, drain counter to 0, o_halted=0, o_bubble_count=0. Reset mid-drain or in HALTED returns to RUN immediately.
- Latency: 1 cycle from ID inputs to o_* outputs.
- Load-use hazard is asserted when all hold:
  - o_mem_read=1
  - o_reg_dir_to_write≠0
  - o_reg_dir_to_write equals i_rs_dir or i_rt_dir
- Bubble = all controls at their reset values; data fields don't-care, and the implementation drives them to 0.
- Per-edge priority:
  - i_step=0: hold everything, counter included.
  - Else state≠RUN: load a bubble.
  - Else i_flush: load a bubble. Flush wins over load-use; no stall.
  - Else load-use: load a bubble; o_stall=1 this cycle, so ID keeps the same instruction and it is recaptured next cycle (exactly one bubble per load-use).
  - Else capture the inputs.
- o_stall = load-use & ~i_flush & (state==RUN), or state≠RUN. It is independent of i_step.
- FSM:
  - RUN: capture with i_halt=1 (step=1, no flush, no load-use) → DRAIN, counter=DRAIN_CYCLES-1.
  - DRAIN: on each stepped edge, counter decrements; at counter 0 → HALTED.
  - HALTED: o_halted=1. Sticky until reset. Outputs remain bubbles.
- A flushed or stalled HALT is not captured and does not start the drain.
- Register 0 is never a hazard destination.

Optional Feature:
- Macro: ID_EX_BUBBLE_COUNTER_EN.
- Defined: o_bubble_count increments on every stepped edge that loads a bubble due to flush or load-use. DRAIN/HALTED bubbles are not counted. Saturates at all-ones. Async-reset to 0.
- Undefined: o_bubble_count tied to 0; no counter flops.

Decomposition:
- decode_constants.vh gains FSM state encodings (ST_RUN=2'd0, ST_DRAIN=2'd1, ST_HALTED=2'd2) and the DRAIN_CYCLES default.
- Bubble reset values reuse RT_ALU_SRC, SIGNED_EXTENSION_MODE and COMPLETE_WORD from the existing headers.
- One sub-module: load_use_detector, combinational (ex_mem_read, ex_rd, id_rs, id_rt → hazard).

Test Plan:
- Capture: i_step=1, inputs = ADDI-style controls (reg_write=1, ALUSrc=imm, rd=5, rs_data=0x10, imm=0x4) → next cycle o_reg_dir_to_write=5, o_rs_data=0x10, o_imm_ext=0x4, o_stall=0.
- Load-use: LW with rd=8 in EX; ID presents rs=8 → o_stall=1 for exactly 1 cycle; next o_* = bubble; following cycle captures the dependent instruction. Repeat with rd=0 → no stall.
- Flush priority: load-use condition plus i_flush=1 → o_stall=0, bubble loaded; o_bubble_count +1 when the macro is defined.
- Halt drain: HALT captured at cycle t → o_halted=0 through t+2, o_halted=1 at t+3 (DRAIN_CYCLES=3); o_stall=1 from t+1 onward; later inputs ignored.
- Step hold: i_step=0 for 5 cycles during DRAIN → counter and outputs frozen; o_halted delayed by 5 cycles.
- Async reset: assert i_reset mid-clock while HALTED → o_halted=0 and controls at reset values before the next edge; state RUN after release.
